// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unpacker.
// Holds the control FSM state type, cache-line geometry and the
// bus tag field layout used when building read requests.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int LINE_BYTES     = 64;
    localparam int BEATS_PER_LINE = 8;
    localparam int INSTS_PER_LINE = 16;
    localparam int BEAT_IDX_W     = $clog2(BEATS_PER_LINE);
    localparam int INST_IDX_W     = $clog2(INSTS_PER_LINE);
    localparam int LINE_OFS_W     = $clog2(LINE_BYTES);

    // Bus tag layout (MSB first): {rw, mem_type[3:0], zero-filled rest}.
    localparam logic       TAG_RW_READ  = 1'b0;
    localparam logic       TAG_RW_WRITE = 1'b1;
    localparam logic [3:0] TAG_MEM_TYPE = 4'b0001;

endpackage

// File: rtl/fetch_line_buffer.sv
// One cache line of fetched data.
// Ports:
//   clk        - clock
//   wr_en_i    - write one bus beat into slot wr_slot_i
//   wr_slot_i  - beat slot 0..7
//   wr_data_i  - beat data (two instructions)
//   rd_idx_i   - instruction index 0..15 (slot = idx[3:1], half = idx[0])
//   rd_word_o  - selected instruction word (combinational)
module fetch_line_buffer
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        wr_en_i,
    input  logic [BEAT_IDX_W-1:0]       wr_slot_i,
    input  logic [BUS_DATA_WIDTH-1:0]   wr_data_i,
    input  logic [INST_IDX_W-1:0]       rd_idx_i,
    output logic [BUS_DATA_WIDTH/2-1:0] rd_word_o
);

    localparam int WORD_W = BUS_DATA_WIDTH / 2;

    // Data storage only; no reset needed since a line is always fully
    // written before it is read.
    logic [BUS_DATA_WIDTH-1:0] mem_q [BEATS_PER_LINE];
    logic [BUS_DATA_WIDTH-1:0] slot;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_slot_i] <= wr_data_i;
    end

    assign slot      = mem_q[rd_idx_i[INST_IDX_W-1:1]];
    assign rd_word_o = rd_idx_i[0] ? slot[BUS_DATA_WIDTH-1 -: WORD_W] : slot[WORD_W-1:0];

endmodule

// File: rtl/fetch_unpacker.sv
// Fetch unpacker: requests 64-byte lines over a burst bus, buffers the
// eight beats and streams 32-bit instructions to the decoder with a
// valid/ready handshake. A zero instruction word ends the program.
// Ports:
//   clk, reset                      - clock, async active-low reset
//   entry                           - first fetch PC (captured during reset)
//   bus_reqcyc/req/reqtag, reqack   - line read request
//   bus_respcyc/resp/resptag, respack - response beats
//   instruction/inst_pc/inst_valid, inst_ready - decoder stream
//   redirect_valid/redirect_pc      - fetch restart
//   halt                            - end of program reached
module fetch_unpacker
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [63:0]                 entry,
    output logic                        bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]   bus_req,
    output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
    input  logic                        bus_reqack,
    input  logic                        bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
    output logic                        bus_respack,
    output logic [BUS_DATA_WIDTH/2-1:0] instruction,
    output logic [63:0]                 inst_pc,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    input  logic                        redirect_valid,
    input  logic [63:0]                 redirect_pc,
    output logic                        halt
);

    localparam int WORD_W = BUS_DATA_WIDTH / 2;

    state_e                  state_q, state_d;
    logic [63:0]             pc_q, pc_d;
    logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
    logic                    redir_q, redir_d;

    logic                    buf_we;
    logic [WORD_W-1:0]       word;
    logic [63:0]             redir_tgt;
    logic [63:0]             line_addr;
    logic [BUS_TAG_WIDTH-1:0] read_tag;
    logic                    redir_any;

    // Response tags are not interpreted; the bus returns beats in order.
    logic unused_inputs;
    assign unused_inputs = ^{bus_resptag, redirect_pc[1:0]};

    assign redir_tgt = {redirect_pc[63:2], 2'b00};
    assign line_addr = {pc_q[63:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
    assign redir_any = redir_q | redirect_valid;

    always_comb begin
        read_tag = '0;
        read_tag[BUS_TAG_WIDTH-1]      = TAG_RW_READ;
        read_tag[BUS_TAG_WIDTH-2 -: 4] = TAG_MEM_TYPE;
    end

    fetch_line_buffer #(.BUS_DATA_WIDTH(BUS_DATA_WIDTH)) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_slot_i (beat_q),
        .wr_data_i (bus_resp),
        .rd_idx_i  (pc_q[LINE_OFS_W-1:2]),
        .rd_word_o (word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= entry;
            beat_q  <= '0;
            redir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            beat_q  <= beat_d;
            redir_q <= redir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        beat_d      = beat_q;
        redir_d     = redir_q;
        buf_we      = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        instruction = '0;
        inst_pc     = '0;
        inst_valid  = 1'b0;
        halt        = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;

            ST_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'(line_addr);
                bus_reqtag = read_tag;
                // A redirect restarts the request; the new address is
                // presented from the next cycle on.
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end else if (bus_reqack) begin
                    beat_d  = '0;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                bus_respack = bus_respcyc;
                // The burst cannot be cut short, so remember the redirect
                // and drop the remaining beats instead of buffering them.
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    redir_d = 1'b1;
                end
                if (bus_respcyc) begin
                    buf_we = ~redir_any;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_IDX_W'(BEATS_PER_LINE - 1)) begin
                        redir_d = 1'b0;
                        state_d = redir_any ? ST_REQ : ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The buffer index is simply pc[5:2], so stepping pc
                // steps the index and a line-crossing pc marks the wrap.
                instruction = word;
                inst_pc     = pc_q;
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = ST_REQ;
                end else if (word == '0) begin
                    state_d = ST_DONE;
                end else begin
                    inst_valid = 1'b1;
                    if (inst_ready) begin
                        pc_d = pc_q + 64'd4;
                        if (pc_q[LINE_OFS_W-1:2] == INST_IDX_W'(INSTS_PER_LINE - 1))
                            state_d = ST_REQ;
                    end
                end
            end

            ST_DONE: halt = 1'b1;

            default: state_d = ST_IDLE;
        endcase
    end

endmodule
